// File: rtl/n101_pwmcapport_pkg.sv
// Shared constants and state encoding for the PWM capture port.
// Optional glitch filter build macro: N101_PWMCAP_FILTER_EN.
package n101_pwmcapport_pkg;

    localparam int unsigned CH_DEF    = 4;
    localparam int unsigned CNT_W_DEF = 16;
`ifdef N101_PWMCAP_FILTER_EN
    localparam int unsigned FILT_N_DEF = 3;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } cap_state_e;

endpackage

// File: rtl/n101_pwmcapport_if.sv
// Capture result bus between the PWM capture port (slave) and the peripheral register block (master).
interface n101_pwmcapport_if
    import n101_pwmcapport_pkg::*;
#(
    parameter int unsigned CH    = CH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic [CH-1:0]       cap_en;
    logic [CH-1:0]       cap_pue;
    logic [CH-1:0]       cap_ack;
    logic [CH*CNT_W-1:0] cap_period;
    logic [CH*CNT_W-1:0] cap_high;
    logic [CH-1:0]       cap_vld;
    logic [CH-1:0]       cap_ovf;
    logic [CH-1:0]       cap_lost;

    modport master (
        output cap_en, cap_pue, cap_ack,
        input  cap_period, cap_high, cap_vld, cap_ovf, cap_lost
    );

    modport slave (
        input  cap_en, cap_pue, cap_ack,
        output cap_period, cap_high, cap_vld, cap_ovf, cap_lost
    );

endinterface

// File: rtl/n101_pwmcap_chan.sv
// One capture channel: pad synchroniser, optional glitch filter (N101_PWMCAP_FILTER_EN),
// arm/measure FSM, saturating period/high counters and result handshake.
module n101_pwmcap_chan
    import n101_pwmcapport_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
`ifdef N101_PWMCAP_FILTER_EN
    ,
    parameter int unsigned FILT_N = FILT_N_DEF
`endif
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ack,
    input  logic             pin,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high,
    output logic             vld,
    output logic             ovf,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sync1_q, sync2_q, s_q, s_d, s_prev_q, rise;
    cap_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic ovf_acc_q, ovf_acc_d, ovf_q, ovf_d, vld_q, vld_d, lost_q, lost_d;

`ifdef N101_PWMCAP_FILTER_EN
    localparam int unsigned FC_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;
    logic [FC_W-1:0] fcnt_q, fcnt_d;

    // s follows the synced input only after FILT_N consecutive differing samples
    always_comb begin
        s_d    = s_q;
        fcnt_d = '0;
        if (sync2_q != s_q) begin
            if (fcnt_q == FC_W'(FILT_N - 1)) begin
                s_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end
`else
    always_comb s_d = sync2_q;
`endif

    assign rise = s_q & ~s_prev_q;

    // FSM, counters and result/handshake next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        ovf_acc_d = ovf_acc_q;
        period_d  = period_q;
        high_d    = high_q;
        ovf_d     = ovf_q;
        vld_d     = vld_q;
        lost_d    = lost_q;

        if (ack && vld_q) begin
            vld_d  = 1'b0;
            lost_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                hcnt_d    = '0;
                ovf_acc_d = 1'b0;
                if (en && rise) begin
                    state_d = ST_MEAS;
                    cnt_d   = CNT_W'(1);
                    hcnt_d  = CNT_W'(1);
                end
            end
            ST_MEAS: begin
                if (!en) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    hcnt_d    = '0;
                    ovf_acc_d = 1'b0;
                end else if (rise) begin
                    period_d  = cnt_q;
                    high_d    = hcnt_q;
                    ovf_d     = ovf_acc_q;
                    vld_d     = 1'b1;
                    if (vld_q && !ack) lost_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                    hcnt_d    = CNT_W'(1);
                    ovf_acc_d = 1'b0;
                end else begin
                    if (cnt_q == CNT_MAX) ovf_acc_d = 1'b1;
                    else                  cnt_d     = cnt_q + CNT_W'(1);
                    if (s_q) begin
                        if (hcnt_q == CNT_MAX) ovf_acc_d = 1'b1;
                        else                   hcnt_d    = hcnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            s_q       <= 1'b0;
            s_prev_q  <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            ovf_acc_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            sync1_q   <= pin;
            sync2_q   <= sync1_q;
            s_q       <= s_d;
            s_prev_q  <= s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            ovf_acc_q <= ovf_acc_d;
            period_q  <= period_d;
            high_q    <= high_d;
            ovf_q     <= ovf_d;
            vld_q     <= vld_d;
            lost_q    <= lost_d;
        end
    end

    assign period = period_q;
    assign high   = high_q;
    assign vld    = vld_q;
    assign ovf    = ovf_q;
    assign lost   = lost_q;

endmodule

// File: rtl/n101_pwmcapport.sv
// PWM capture pin port: CH input-only pads, one measurement channel per pin.
// Glitch filter in every channel when N101_PWMCAP_FILTER_EN is defined.
module n101_pwmcapport
    import n101_pwmcapport_pkg::*;
#(
    parameter int unsigned CH    = CH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
`ifdef N101_PWMCAP_FILTER_EN
    ,
    parameter int unsigned FILT_N = FILT_N_DEF
`endif
) (
    input  logic            clock,
    input  logic            rst_n,
    n101_pwmcapport_if.slave cap,
    input  logic [CH-1:0]   io_pins_ival,
    output logic [CH-1:0]   io_pins_oval,
    output logic [CH-1:0]   io_pins_oe,
    output logic [CH-1:0]   io_pins_ie,
    output logic [CH-1:0]   io_pins_pue,
    output logic [CH-1:0]   io_pins_ds
);

    // Pads are permanently inputs; only the pull-up is software controlled
    assign io_pins_oval = '0;
    assign io_pins_oe   = '0;
    assign io_pins_ie   = '1;
    assign io_pins_pue  = cap.cap_pue;
    assign io_pins_ds   = '0;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        n101_pwmcap_chan #(
            .CNT_W (CNT_W)
`ifdef N101_PWMCAP_FILTER_EN
            ,
            .FILT_N(FILT_N)
`endif
        ) u_chan (
            .clock (clock),
            .rst_n (rst_n),
            .en    (cap.cap_en[i]),
            .ack   (cap.cap_ack[i]),
            .pin   (io_pins_ival[i]),
            .period(cap.cap_period[i*CNT_W +: CNT_W]),
            .high  (cap.cap_high[i*CNT_W +: CNT_W]),
            .vld   (cap.cap_vld[i]),
            .ovf   (cap.cap_ovf[i]),
            .lost  (cap.cap_lost[i])
        );
    end

endmodule

// File: tb/tb_n101_pwmcapport.sv
// Scoreboard bench for n101_pwmcapport: stimulus pushes expected results, a negedge monitor pops on every output change.
module tb_n101_pwmcapport;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 16;
`ifdef N101_PWMCAP_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic [CW-1:0] period;
        logic [CW-1:0] high;
        logic          ovf;
        logic          vld;
        logic          lost;
    } res_t;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [CH-1:0] pins;
    logic [CH-1:0] oval, oe, ie, pue, ds;

    n101_pwmcapport_if #(.CH(CH), .CNT_W(CW)) cap_if ();

    n101_pwmcapport #(.CH(CH), .CNT_W(CW)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .cap         (cap_if),
        .io_pins_ival(pins),
        .io_pins_oval(oval),
        .io_pins_oe  (oe),
        .io_pins_ie  (ie),
        .io_pins_pue (pue),
        .io_pins_ds  (ds)
    );

    always #5 clock = ~clock;

    res_t exp_q[CH][$];
    res_t prev[CH];
    res_t mon_cur, mon_exp;
    bit   mon_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    function automatic res_t get_res(input int ch);
        res_t r;
        r.period = cap_if.cap_period[ch*CW +: CW];
        r.high   = cap_if.cap_high[ch*CW +: CW];
        r.ovf    = cap_if.cap_ovf[ch];
        r.vld    = cap_if.cap_vld[ch];
        r.lost   = cap_if.cap_lost[ch];
        return r;
    endfunction

    // Every change of a channel's result tuple must match the next queued expectation
    always @(negedge clock) begin
        if (mon_en) begin
            for (int c = 0; c < CH; c++) begin
                mon_cur = get_res(c);
                if (mon_cur !== prev[c]) begin
                    n_vec++;
                    if (exp_q[c].size() == 0) begin
                        n_err++;
                        $display("FAIL ch%0d unexpected: got p=%0d h=%0d ovf=%0b vld=%0b lost=%0b",
                                 c, mon_cur.period, mon_cur.high, mon_cur.ovf, mon_cur.vld, mon_cur.lost);
                    end else begin
                        mon_exp = exp_q[c].pop_front();
                        if (mon_cur !== mon_exp) begin
                            n_err++;
                            $display("FAIL ch%0d result: got p=%0d h=%0d ovf=%0b vld=%0b lost=%0b want p=%0d h=%0d ovf=%0b vld=%0b lost=%0b",
                                     c, mon_cur.period, mon_cur.high, mon_cur.ovf, mon_cur.vld, mon_cur.lost,
                                     mon_exp.period, mon_exp.high, mon_exp.ovf, mon_exp.vld, mon_exp.lost);
                        end
                    end
                    prev[c] = mon_cur;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input int ch, input int p, input int h, input bit o, input bit v, input bit l);
        res_t r;
        r.period = CW'(p);
        r.high   = CW'(h);
        r.ovf    = o;
        r.vld    = v;
        r.lost   = l;
        exp_q[ch].push_back(r);
    endtask

    task automatic pulse(input int ch, input int h, input int l);
        pins[ch] = 1'b1;
        wait_cyc(h);
        pins[ch] = 1'b0;
        wait_cyc(l);
    endtask

    task automatic do_ack(input int ch);
        cap_if.cap_ack[ch] = 1'b1;
        wait_cyc(1);
        cap_if.cap_ack[ch] = 1'b0;
    endtask

    // Ack lands on exactly the edge that captures this pulse's rise
    task automatic pulse_ack(input int ch, input int h, input int l);
        pins[ch] = 1'b1;
        wait_cyc(LAT);
        cap_if.cap_ack[ch] = 1'b1;
        wait_cyc(1);
        cap_if.cap_ack[ch] = 1'b0;
        wait_cyc(h - LAT - 1);
        pins[ch] = 1'b0;
        wait_cyc(l);
    endtask

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        pins           = '0;
        cap_if.cap_en  = '0;
        cap_if.cap_pue = 4'b1010;
        cap_if.cap_ack = '0;
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        wait_cyc(2);

        chk("rst_period", int'(|cap_if.cap_period), 0);
        chk("rst_high",   int'(|cap_if.cap_high), 0);
        chk("rst_vld",    int'(cap_if.cap_vld), 0);
        chk("rst_ovf",    int'(cap_if.cap_ovf), 0);
        chk("rst_lost",   int'(cap_if.cap_lost), 0);
        chk("pad_oval",   int'(oval), 0);
        chk("pad_oe",     int'(oe), 0);
        chk("pad_ie",     int'(ie), 15);
        chk("pad_ds",     int'(ds), 0);
        chk("pad_pue",    int'(pue), 10);

        for (int c = 0; c < CH; c++) prev[c] = get_res(c);
        mon_en        = 1'b1;
        cap_if.cap_en = 4'b0011;

        // Basic capture, overwrite, ack, ignored ack
        pulse(0, 4, 6);
        push(0, 10, 4, 0, 1, 0);  pulse(0, 3, 5);
        push(0, 8, 3, 0, 1, 1);   pulse(0, 5, 7);
        push(0, 8, 3, 0, 0, 0);   do_ack(0);
        do_ack(0);
        push(0, 14, 5, 0, 1, 0);  pulse(0, 6, 4);
        push(0, 10, 6, 0, 1, 1);  pulse(0, 3, 6);
        // Ack coincident with capture
        push(0, 9, 3, 0, 1, 0);   pulse_ack(0, 6, 5);
        push(0, 9, 3, 0, 0, 0);   do_ack(0);

        // Constant high long enough to saturate both counters
        push(0, 12, 6, 0, 1, 0);
        pins[0] = 1'b1;
        wait_cyc(70000);
        pins[0] = 1'b0;
        wait_cyc(4);
        push(0, 65535, 65535, 1, 1, 1);  pulse(0, 4, 4);
        push(0, 8, 4, 0, 1, 1);          pulse(0, 3, 3);

        // Capture latency on channel 1
        pulse(1, 4, 4);
        push(1, 8, 4, 0, 1, 0);
        pins[1] = 1'b1;
        wait_cyc(LAT);
        chk("lat_vld_before", int'(cap_if.cap_vld[1]), 0);
        wait_cyc(1);
        chk("lat_vld_at", int'(cap_if.cap_vld[1]), 1);
        wait_cyc(6 - LAT - 1);
        pins[1] = 1'b0;
        wait_cyc(4);
        push(1, 8, 4, 0, 0, 0);  do_ack(1);

        // Disabled channels never capture; re-enable re-arms first
        cap_if.cap_en[1] = 1'b0;
        pulse(1, 4, 4);
        pulse(2, 4, 4);
        pulse(2, 4, 4);
        cap_if.cap_en[1] = 1'b1;
        pulse(1, 4, 4);
        push(1, 8, 4, 0, 1, 0);  pulse(1, 3, 3);

        // Reset mid-measurement
        push(0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        pulse(0, 3, 4);
        push(0, 7, 3, 0, 1, 0);  pulse(0, 4, 4);

`ifdef N101_PWMCAP_FILTER_EN
        // Short glitch is filtered away; clean pulses measure exactly
        pulse(1, 5, 7);
        pulse(1, 2, 10);
        push(1, 24, 5, 0, 1, 0);  pulse(1, 5, 7);
        push(1, 12, 5, 0, 1, 1);  pulse(1, 3, 3);
`endif

        wait_cyc(10);
        for (int c = 0; c < CH; c++) begin
            n_vec++;
            if (exp_q[c].size() != 0) begin
                n_err++;
                $display("FAIL ch%0d missing results: got %0d pending want 0", c, exp_q[c].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
